// File: rtl/spi_acl_pkg.sv
// Shared definitions for the accelerometer SPI slot core: register offsets,
// ctrl bit positions and the transfer FSM state encoding.
package spi_acl_pkg;

  localparam logic [4:0] REG_STATUS = 5'd0;
  localparam logic [4:0] REG_SS     = 5'd2;
  localparam logic [4:0] REG_CTRL   = 5'd3;
  localparam logic [4:0] REG_DATA   = 5'd4;

  localparam int CTRL_CPHA_BIT = 16;
  localparam int CTRL_CPOL_BIT = 17;
  localparam int CTRL_LOOP_BIT = 18;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPHA_DLY = 2'd1,
    P0       = 2'd2,
    P1       = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_acl_engine.sv
// SPI byte engine: divider, transfer FSM and shift registers. A start pulse
// is only accepted in IDLE; rx_byte and ready update together at the end.
module spi_acl_engine
  import spi_acl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  tx_byte,
  input  logic [15:0] dvsr,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        miso,
  output logic        ready,
  output logic [7:0]  rx_byte,
  output logic        sclk,
  output logic        mosi,
  output spi_state_e  state
);

  logic [15:0] c;
  logic [2:0]  n;
  logic [7:0]  so;
  logic [7:0]  si;
  logic        phase_end;

  assign phase_end = (c == dvsr);
  // so is only touched on start/shift, so mosi naturally holds in IDLE.
  assign mosi = so[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      rx_byte <= 8'h00;
      sclk    <= 1'b0;
      so      <= 8'h00;
      si      <= 8'h00;
      c       <= 16'd0;
      n       <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          // The delay phase and a cpha=0 P0 both sit at the idle level.
          sclk <= cpol;
          if (start) begin
            so    <= tx_byte;
            n     <= 3'd0;
            c     <= 16'd0;
            ready <= 1'b0;
            state <= cpha ? CPHA_DLY : P0;
          end
        end
        CPHA_DLY: begin
          if (phase_end) begin
            c     <= 16'd0;
            sclk  <= cpol ^ cpha;
            state <= P0;
          end else begin
            c <= c + 16'd1;
          end
        end
        P0: begin
          if (phase_end) begin
            c     <= 16'd0;
            si    <= {si[6:0], miso};
            sclk  <= ~(cpol ^ cpha);
            state <= P1;
          end else begin
            c <= c + 16'd1;
          end
        end
        P1: begin
          if (phase_end) begin
            c <= 16'd0;
            if (n == 3'd7) begin
              rx_byte <= si;
              ready   <= 1'b1;
              sclk    <= cpol;
              state   <= IDLE;
            end else begin
              so    <= {so[6:0], 1'b0};
              n     <= n + 3'd1;
              sclk  <= cpol ^ cpha;
              state <= P0;
            end
          end else begin
            c <= c + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_acl_core.sv
// MMIO slot wrapper for the accelerometer SPI: register file and read mux.
// Define SPI_LOOPBACK_EN to add ctrl bit 18, routing spi_mosi back as MISO.
module spi_acl_core
  import spi_acl_pkg::*;
#(
  parameter int          S        = 1,
  parameter logic [15:0] DVSR_RST = 16'd49
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic [S-1:0] spi_ss_n
);

  logic         wr_en;
  logic [S-1:0] ss_n_reg;
  logic [15:0]  dvsr;
  logic         cpol;
  logic         cpha;
  logic         ready;
  logic [7:0]   rx_byte;
  logic         miso_src;
  logic         unused_ok;
  spi_state_e   eng_state;

  assign wr_en    = cs & write;
  assign spi_ss_n = ss_n_reg;

`ifdef SPI_LOOPBACK_EN
  logic loop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop <= 1'b0;
    end else if (wr_en && addr == REG_CTRL) begin
      loop <= wr_data[CTRL_LOOP_BIT];
    end
  end

  assign miso_src  = loop ? spi_mosi : spi_miso;
  assign unused_ok = ^{read, wr_data[31:19], eng_state};
`else
  assign miso_src  = spi_miso;
  assign unused_ok = ^{read, wr_data[31:18], eng_state};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_n_reg <= '1;
      dvsr     <= DVSR_RST;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
    end else if (wr_en) begin
      if (addr == REG_SS) begin
        ss_n_reg <= wr_data[S-1:0];
      end
      if (addr == REG_CTRL) begin
        dvsr <= wr_data[15:0];
        cpha <= wr_data[CTRL_CPHA_BIT];
        cpol <= wr_data[CTRL_CPOL_BIT];
      end
    end
  end

  assign rd_data = (addr == REG_STATUS) ? {23'b0, ready, rx_byte} : 32'h0;

  spi_acl_engine u_engine (
    .clk     (clk),
    .rst_n   (reset_n),
    .start   (wr_en && addr == REG_DATA),
    .tx_byte (wr_data[7:0]),
    .dvsr    (dvsr),
    .cpol    (cpol),
    .cpha    (cpha),
    .miso    (miso_src),
    .ready   (ready),
    .rx_byte (rx_byte),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .state   (eng_state)
  );

endmodule

// File: tb/tb_spi_acl_core.sv
// Scoreboard bench for spi_acl_core: a behavioural SPI slave model, a bus
// driver, and a monitor that checks each completed transfer against exp_q.
module tb_spi_acl_core;

  localparam int S = 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cs = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [4:0]   addr = 5'd0;
  logic [31:0]  wr_data = 32'h0;
  logic [31:0]  rd_data;
  logic         spi_sclk;
  logic         spi_mosi;
  logic         spi_miso;
  logic [S-1:0] spi_ss_n;

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_acl_core #(.S(S), .DVSR_RST(16'd49)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_tx_q[$];
  int         exp_len_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural SPI slave: mode given by cur_cpol/cur_cpha
  logic       cur_cpol = 1'b0;
  logic       cur_cpha = 1'b0;
  logic       slave_drive = 1'b0;
  logic       slave_active = 1'b0;
  logic [7:0] s_byte = 8'h00;
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic       s_out = 1'b0;
  int         sl_edges = 0;

  assign spi_miso = slave_drive ? s_out : 1'b0;

  initial begin
    forever begin
      wait (slave_active);
      s_tx = s_byte;
      s_rx = 8'h00;
      sl_edges = 0;
      s_out = s_byte[7];
      while (slave_active) begin
        @(spi_sclk or negedge slave_active);
        if (slave_active) begin
          sl_edges++;
          // leading edge = sclk leaving its idle level
          if ((spi_sclk != cur_cpol) == (cur_cpha == 1'b0)) begin
            s_rx = {s_rx[6:0], spi_mosi};
          end else if (cur_cpha == 1'b0) begin
            s_tx = {s_tx[6:0], 1'b0};
            s_out = s_tx[7];
          end else begin
            s_out = s_tx[7];
            s_tx = {s_tx[6:0], 1'b0};
          end
        end
      end
    end
  end

  // Monitor: a rising ready (seen on status reads) completes a transfer
  initial begin
    logic       prev;
    int         t_fall;
    logic [7:0] e;
    prev = 1'b1;
    t_fall = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b1;
      end else if (addr == 5'd0) begin
        if (prev && !rd_data[8]) t_fall = cyc;
        if (!prev && rd_data[8]) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got rd_data 0x%0h expected no completion", rd_data);
          end else begin
            e = exp_q.pop_front();
            check("rx_word", rd_data, {23'b0, 1'b1, e});
            check("slave_rx", {24'b0, s_rx}, {24'b0, exp_tx_q.pop_front()});
            check("busy_len", cyc - t_fall, exp_len_q.pop_front());
            check("sclk_edges", sl_edges, 32'd16);
          end
        end
        prev = rd_data[8];
      end
    end
  end

  // driver tasks
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    cs = 1'b1;
    write = 1'b1;
    addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0;
    write = 1'b0;
    addr = 5'd0;
    wr_data = 32'h0;
  endtask

  int cur_dvsr = 49;

  task automatic set_ctrl(input logic [31:0] v);
    bus_write(5'd3, v);
    cur_dvsr = int'(v[15:0]);
    cur_cpha = v[16];
    cur_cpol = v[17];
    repeat (3) @(posedge clk);
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] sb,
                            input logic drive, input logic [7:0] exp_rx);
    s_byte = sb;
    slave_drive = drive;
    slave_active = 1'b1;
    exp_q.push_back(exp_rx);
    exp_tx_q.push_back(tx);
    exp_len_q.push_back((cur_cpha ? 17 : 16) * (cur_dvsr + 1));
    bus_write(5'd4, {24'b0, tx});
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    check("done_in_time", exp_q.size(), 32'd0);
    exp_q.delete();
    exp_tx_q.delete();
    exp_len_q.delete();
    @(posedge clk);
    slave_active = 1'b0;
    slave_drive = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tx;
    logic [7:0] sb;
    logic [1:0] mode;
    int         d;
    logic [7:0] lb_exp;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk_low", {31'b0, spi_sclk}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_status", rd_data, 32'h100);
    check("rst_ss_n", {31'b0, spi_ss_n}, 32'd1);
    check("rst_sclk", {31'b0, spi_sclk}, 32'd0);
    check("rst_mosi", {31'b0, spi_mosi}, 32'd0);
    addr = 5'd3;
    #1;
    check("rd_other_zero", rd_data, 32'h0);
    addr = 5'd0;

    // mode 0, dvsr=1
    set_ctrl(32'h00001);
    bus_write(5'd2, 32'h0);
    check("ss_low", {31'b0, spi_ss_n}, 32'd0);
    start_xfer(8'hA5, 8'h3C, 1'b1, 8'h3C);
    wait_done(100);

    // mode 3, dvsr=0
    set_ctrl(32'h30000);
    check("sclk_idle_high", {31'b0, spi_sclk}, 32'd1);
    start_xfer(8'h5A, 8'h96, 1'b1, 8'h96);
    wait_done(60);

    // start write mid-transfer is ignored
    set_ctrl(32'h00002);
    start_xfer(8'h81, 8'h7E, 1'b1, 8'h7E);
    repeat (10) @(posedge clk);
    bus_write(5'd4, 32'hFF);
    wait_done(100);
    repeat (60) @(posedge clk);
    check("single_done", exp_q.size(), 32'd0);

    // async reset at bit 4 of a transfer
    set_ctrl(32'h00001);
    start_xfer(8'hFF, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 200 && sl_edges < 9; i++) @(posedge clk);
    check("reached_bit4", {31'b0, sl_edges >= 9}, 32'd1);
    #3;
    slave_active = 1'b0;
    slave_drive = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst_sclk", {31'b0, spi_sclk}, 32'd0);
    check("arst_mosi", {31'b0, spi_mosi}, 32'd0);
    check("arst_ss_n", {31'b0, spi_ss_n}, 32'd1);
    check("arst_status", rd_data, 32'h100);
    exp_q.delete();
    exp_tx_q.delete();
    exp_len_q.delete();
    cur_cpol = 1'b0;
    cur_cpha = 1'b0;
    cur_dvsr = 49;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus_write(5'd2, 32'h0);
    start_xfer(8'h6D, 8'hB2, 1'b1, 8'hB2);
    wait_done(1000);

    // loopback source selection
`ifdef SPI_LOOPBACK_EN
    lb_exp = 8'hC3;
`else
    lb_exp = 8'h00;
`endif
    set_ctrl(32'h40001);
    start_xfer(8'hC3, 8'hFF, 1'b0, lb_exp);
    wait_done(100);

    // randomized modes, dividers and data
    for (int k = 0; k < 12; k++) begin
      mode = 2'($urandom_range(0, 3));
      d = $urandom_range(0, 3);
      tx = 8'($urandom_range(0, 255));
      sb = 8'($urandom_range(0, 255));
      set_ctrl({14'b0, mode, 16'(d)});
      start_xfer(tx, sb, 1'b1, sb);
      wait_done(17 * (d + 1) + 20);
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_acl_core.md
Name: spi_acl_core

Overview:
- MMIO slot core driving the board accelerometer SPI pins (acl_sclk/acl_mosi/acl_miso/acl_ss_n); sits downstream of the mmio_sys slot decoder, one slot.
- Firmware writes a byte; the core shifts it out MSB-first on MOSI while capturing MISO, then flags ready with the received byte readable.
- Programmable clock divider, CPOL/CPHA and a slave-select register.

Parameters:
- S, 1, number of slave-select lines.
- DVSR_RST, 49, reset divider value (sclk = 100 MHz / (2*(dvsr+1)), so 1 MHz at reset).

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous active-low reset.
- cs  in  1  slot select.
- read  in  1  read strobe (unused internally; reads have no side effects).
- write  in  1  write strobe.
- addr  in  5  word offset within slot.
- wr_data  in  32  write data.
- rd_data  out  32  read data.
- spi_sclk  out  1  SPI clock.
- spi_mosi  out  1  SPI data out.
- spi_miso  in  1  SPI data in.
- spi_ss_n  out  S  active-low slave selects.

Behaviour:
- Register map (write = cs & write):
  - off 0 R: rd_data = {23'b0, ready, rx_byte[7:0]}.
  - off 2 W: ss_n_reg <= wr_data[S-1:0].
  - off 3 W: dvsr <= wr_data[15:0]; cpha <= wr_data[16]; cpol <= wr_data[17].
  - off 4 W: tx_byte <= wr_data[7:0] and start transfer.
- rd_data is combinational on addr; offsets other than 0 read 0.
- Reset (async, immediate, any state): FSM -> IDLE, ready=1, rx_byte=0, ss_n_reg=all 1s, dvsr=DVSR_RST, cpol=0, cpha=0.
  - Outputs at reset: spi_sclk=0, spi_mosi=0, spi_ss_n=all 1s.
- spi_ss_n = ss_n_reg directly; the core never toggles it itself.
- Divider counter c counts 0..dvsr, then a phase ends.
- FSM states: IDLE, CPHA_DLY, P0, P1.
- IDLE: ready=1, sclk=cpol.
  - Start write: load shift register, bit count n=0, c=0.
  - Next state CPHA_DLY if cpha, else P0; ready drops the cycle after the write.
- CPHA_DLY: hold one phase (dvsr+1 clks), then P0.
- P0 (sclk = cpol ^ cpha): at phase end, sample miso into the shift-in LSB, then go to P1.
- P1 (sclk = ~(cpol ^ cpha)): at phase end:
  - if n==7, go to IDLE with rx_byte <= shift-in;
  - else shift out the next MOSI bit, n++, go to P0.
- spi_mosi = shift-out MSB at all times in non-IDLE states; holds its last value in IDLE.
- Transfer length: 16*(dvsr+1) clks (cpha=0) or 17*(dvsr+1) clks (cpha=1) from the first non-IDLE cycle to the return to IDLE.
- ready=1 and rx_byte are valid on the same cycle; rx_byte is stable until the next transfer completes.
- Start write while not IDLE: ignored entirely, tx_byte is not updated.
- Ctrl writes mid-transfer take effect immediately; firmware must not do this (behaviour is defined but not meaningful).
- dvsr=0 is legal: one clk per phase.

Optional Feature:
- Macro SPI_LOOPBACK_EN.
  - Defined: adds ctrl bit 18 (loop, reset 0). When loop=1, the internal MISO sample source is spi_mosi and the spi_miso pin is ignored; spi_sclk, spi_mosi and spi_ss_n still drive the pins.
  - Undefined: bit 18 is ignored and MISO always comes from the pin.

Decomposition:
- Package spi_acl_pkg holds:
  - register offset localparams (REG_STATUS=0, REG_SS=2, REG_CTRL=3, REG_DATA=4);
  - state enum typedef {IDLE, CPHA_DLY, P0, P1};
  - ctrl bit-position constants.
- One sub-module, spi_acl_engine: the FSM, divider and shift registers.
  - Inputs: start, tx_byte, dvsr, cpol, cpha.
  - Outputs: ready, rx_byte, sclk, mosi.
  - The top core keeps only the register file and read mux.

Test Plan:
- Reset, then read off 0 -> 0x100; spi_ss_n=1, spi_sclk=0, spi_mosi=0.
- Write ctrl=0x00001 (dvsr=1, mode 0); ss=0; data=0xA5; slave model returns 0x3C -> MOSI bits 1,0,1,0,0,1,0,1 on rising edges; 8 sclk pulses; ready low for 32 clks; then off 0 reads 0x13C.
- Write ctrl=0x30000 (mode 3, dvsr=0); data=0x5A -> sclk idles high; extra leading phase; transfer takes 17 clks; rx equals model byte.
- During a transfer, write data=0xFF -> ignored; MOSI still carries the original byte; ready returns once.
- Assert reset_n low at bit 4 of a transfer -> outputs return to reset values asynchronously; the next transfer after release completes normally.
- With SPI_LOOPBACK_EN: write ctrl=0x40001; data=0xC3, spi_miso tied 0 -> rx_byte=0xC3. Without the macro, the same stimulus gives rx_byte=0x00.
